event_drain: RTL

Drains a bank of sticky event flags and reports them as a stream of individual events. It sits on the consumer side of an accumulator stage. Each cycle it watches the accumulated flags. When any flag is set, it snapshots the flags and pulses the accumulator's load/clear input in that same cycle. It then emits one indexed event per set bit over a valid/ready interface, lowest index first. An optional holdoff period lets further events batch up before the next snapshot.

---
 rtl/event_drain.sv | 114 +++++++++++
 1 files changed

// File: rtl/event_drain.sv
// event_drain: snapshots a bank of sticky event flags and streams one indexed event per set bit.
// Optional snapshot timestamp via EVENT_DRAIN_TIMESTAMP_EN.
module event_drain #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned HOLDOFF = 0,
    parameter int unsigned TS_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] acc,
    output logic             acc_clear,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_idx,
    output logic             ev_last,
    output logic             busy
`ifdef EVENT_DRAIN_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  ev_ts
`endif
);

    localparam int unsigned HOLD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        HOLD
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  pending;
    logic [WIDTH-1:0]  rest;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              last_q;

    function automatic logic [IDX_W-1:0] lowest(input logic [WIDTH-1:0] v);
        lowest = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) lowest = IDX_W'(i);
        end
    endfunction

    function automatic logic single(input logic [WIDTH-1:0] v);
        single = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // pending with its lowest set bit removed
    assign rest      = pending & (pending - WIDTH'(1));
    assign acc_clear = (state == IDLE) && (|acc) && !reset;
    assign ev_valid  = (state == DRAIN);
    assign ev_last   = (state == DRAIN) && last_q;
    assign ev_idx    = idx_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            hold_cnt <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_clear) begin
                        pending <= acc;
                        idx_q   <= lowest(acc);
                        last_q  <= single(acc);
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ev_ready) begin
                        pending <= rest;
                        idx_q   <= lowest(rest);
                        last_q  <= single(rest);
                        if (last_q) begin
                            if (HOLDOFF == 0) begin
                                state <= IDLE;
                            end else begin
                                hold_cnt <= HOLD_W'(HOLDOFF - 1);
                                state    <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) state <= IDLE;
                    else                hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EVENT_DRAIN_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // free-running cycle counter, captured on the snapshot cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
            ev_ts  <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (acc_clear) ev_ts <= ts_cnt;
        end
    end
`endif

endmodule
